// File: rtl/apb_servo_pwm_array_pkg.sv
// Shared register map, STATUS bit positions and default timing for the servo PWM array.
package apb_servo_pwm_array_pkg;

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_PERIOD = 8'h04;
    localparam logic [7:0] ADDR_STATUS = 8'h08;
    localparam logic [7:0] ADDR_IRQ_EN = 8'h0C;
    localparam logic [7:0] CH_BASE     = 8'h10;
    localparam int unsigned CH_STRIDE  = 8;

    localparam int unsigned STATUS_HIT   = 0;
    localparam int unsigned STATUS_LEVEL = 1;

    // 20 ms at 50 MHz
    localparam int unsigned DEFAULT_RESET_PERIOD = 1_000_000;

endpackage

// File: rtl/servo_pwm_channel.sv
// One PWM channel: slew-limited duty tracking at period wrap and a registered compare output.
module servo_pwm_channel #(
    parameter int unsigned CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] per_act,
    input  logic             wrap,
    input  logic             en,
    input  logic [CNT_W-1:0] duty,
    input  logic [CNT_W-1:0] step,
    output logic             pwm
);

    logic [CNT_W-1:0] cur_q;
    logic [CNT_W-1:0] diff;
    logic [CNT_W-1:0] cur_nxt;

    // Distance is taken before stepping so the add/subtract can never wrap.
    always_comb begin
        diff    = (duty >= cur_q) ? (duty - cur_q) : (cur_q - duty);
        cur_nxt = cur_q;
        if ((step == '0) || (diff <= step)) begin
            cur_nxt = duty;
        end else if (duty > cur_q) begin
            cur_nxt = cur_q + step;
        end else begin
            cur_nxt = cur_q - step;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_q <= '0;
            pwm   <= 1'b0;
        end else begin
            if (wrap) begin
                cur_q <= cur_nxt;
            end
            pwm <= en && (per_act != '0) && (cnt < cur_q);
        end
    end

endmodule

// File: rtl/apb_servo_pwm_array.sv
// APB3 servo PWM array: register file, shared period counter, hit detect with sticky flag and IRQ.
module apb_servo_pwm_array
    import apb_servo_pwm_array_pkg::*;
#(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned CNT_W        = 20,
    parameter int unsigned RESET_PERIOD = DEFAULT_RESET_PERIOD
) (
    input  logic              PCLK,
    input  logic              PRESERN,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [7:0]        PADDR,
    input  logic [31:0]       PWDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [31:0]       PRDATA,
    input  logic              hit_data,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              FABINT
);

    localparam logic [4:0] CH_LIM   = 5'(NUM_CH);
    localparam int unsigned STRIDE_SH = $clog2(CH_STRIDE);

    logic [NUM_CH-1:0] ctrl_q;
    logic [CNT_W-1:0]  period_q;
    logic              irq_en_q;
    logic [CNT_W-1:0]  duty_q [NUM_CH];
    logic [CNT_W-1:0]  step_q [NUM_CH];

    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  per_act_q;
    logic              wrap;

    logic              sync1_q, sync2_q, sync3_q, hit_q;

    logic [7:0]        addr_b;
    logic [7:0]        ch_off;
    logic [4:0]        ch_idx;
    logic              is_step;
    logic              in_ch;
    logic              hit_map;
    logic              wr_en;
    logic [31:0]       rdata;
    logic              unused_bits;

    // Address decode
    assign addr_b  = {PADDR[7:2], 2'b00};
    assign ch_off  = addr_b - CH_BASE;
    assign ch_idx  = 5'(ch_off >> STRIDE_SH);
    assign is_step = ch_off[2];
    assign in_ch   = (addr_b >= CH_BASE) && (ch_idx < CH_LIM);
    assign hit_map = (addr_b == ADDR_CTRL) || (addr_b == ADDR_PERIOD) ||
                     (addr_b == ADDR_STATUS) || (addr_b == ADDR_IRQ_EN) || in_ch;
    assign wr_en   = PSEL && PENABLE && PWRITE && hit_map;

    assign unused_bits = ^{PADDR[1:0], PWDATA, ch_off[1:0]};

    // Register file
    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            ctrl_q   <= '0;
            period_q <= CNT_W'(RESET_PERIOD);
            irq_en_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_q[i] <= '0;
                step_q[i] <= '0;
            end
        end else if (wr_en) begin
            if (addr_b == ADDR_CTRL)   ctrl_q   <= PWDATA[NUM_CH-1:0];
            if (addr_b == ADDR_PERIOD) period_q <= PWDATA[CNT_W-1:0];
            if (addr_b == ADDR_IRQ_EN) irq_en_q <= PWDATA[0];
            for (int i = 0; i < NUM_CH; i++) begin
                if (in_ch && (ch_idx == 5'(i))) begin
                    if (is_step) step_q[i] <= PWDATA[CNT_W-1:0];
                    else         duty_q[i] <= PWDATA[CNT_W-1:0];
                end
            end
        end
    end

    // Read mux; unmapped addresses fall through to zero
    always_comb begin
        rdata = '0;
        if (addr_b == ADDR_CTRL)   rdata = 32'(ctrl_q);
        if (addr_b == ADDR_PERIOD) rdata = 32'(period_q);
        if (addr_b == ADDR_STATUS) begin
            rdata[STATUS_HIT]   = hit_q;
            rdata[STATUS_LEVEL] = sync2_q;
        end
        if (addr_b == ADDR_IRQ_EN) rdata = 32'(irq_en_q);
        for (int i = 0; i < NUM_CH; i++) begin
            if (in_ch && (ch_idx == 5'(i))) begin
                rdata = is_step ? 32'(step_q[i]) : 32'(duty_q[i]);
            end
        end
    end

    assign PREADY  = 1'b1;
    assign PSLVERR = PSEL && PENABLE && !hit_map;
    assign PRDATA  = PSEL ? rdata : '0;

    // A zero active period makes every cycle a boundary so a new PERIOD is picked up at once.
    assign wrap = (per_act_q == '0) || (cnt_q == per_act_q - CNT_W'(1));

    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            cnt_q     <= '0;
            per_act_q <= CNT_W'(RESET_PERIOD);
        end else if (wrap) begin
            cnt_q     <= '0;
            per_act_q <= period_q;
        end else begin
            cnt_q     <= cnt_q + CNT_W'(1);
        end
    end

    // Hit synchroniser, edge detect and sticky flag; a new edge beats a same-cycle clear.
    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            hit_q   <= 1'b0;
            FABINT  <= 1'b0;
        end else begin
            sync1_q <= hit_data;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            if (sync2_q && !sync3_q) begin
                hit_q <= 1'b1;
            end else if (wr_en && (addr_b == ADDR_STATUS) && PWDATA[STATUS_HIT]) begin
                hit_q <= 1'b0;
            end
            FABINT <= hit_q && irq_en_q;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        servo_pwm_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk     (PCLK),
            .rst_n   (PRESERN),
            .cnt     (cnt_q),
            .per_act (per_act_q),
            .wrap    (wrap),
            .en      (ctrl_q[g]),
            .duty    (duty_q[g]),
            .step    (step_q[g]),
            .pwm     (pwm_out[g])
        );
    end

endmodule
